// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: operator codes, FSM states, byte-lane
// constants and helpers that classify operators and position store data.
package mem_access_unit_pkg;

    localparam logic [7:0] OPERATOR_NOP  = 8'h00;
    localparam logic [7:0] OPERATOR_ADDU = 8'h01;
    localparam logic [7:0] OPERATOR_SUBU = 8'h02;
    localparam logic [7:0] OPERATOR_LB   = 8'h20;
    localparam logic [7:0] OPERATOR_LH   = 8'h21;
    localparam logic [7:0] OPERATOR_LWL  = 8'h22;
    localparam logic [7:0] OPERATOR_LW   = 8'h23;
    localparam logic [7:0] OPERATOR_LBU  = 8'h24;
    localparam logic [7:0] OPERATOR_LHU  = 8'h25;
    localparam logic [7:0] OPERATOR_LWR  = 8'h26;
    localparam logic [7:0] OPERATOR_SB   = 8'h28;
    localparam logic [7:0] OPERATOR_SH   = 8'h29;
    localparam logic [7:0] OPERATOR_SWL  = 8'h2A;
    localparam logic [7:0] OPERATOR_SW   = 8'h2B;
    localparam logic [7:0] OPERATOR_SWR  = 8'h2E;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_REQ   = 2'd1,
        STATE_WAIT  = 2'd2,
        STATE_DRAIN = 2'd3
    } mem_state_e;

    // Big-endian lanes: bit 3 of a select is bits [31:24] (address offset 0).
    localparam logic [3:0] SEL_BYTE_HI = 4'b1000;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU,
            OPERATOR_LW, OPERATOR_LWL, OPERATOR_LWR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            OPERATOR_SB, OPERATOR_SH, OPERATOR_SW,
            OPERATOR_SWL, OPERATOR_SWR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: return a[0];
            OPERATOR_LW, OPERATOR_SW:               return a != 2'b00;
            default:                                return 1'b0;
        endcase
    endfunction

    // Halfword accesses only look at a[1]; word accesses ignore a[1:0].
    function automatic logic [3:0] mem_sel(input logic [7:0] op, input logic [1:0] a);
        logic [1:0] inv;
        inv = 2'd3 - a;
        case (op)
            OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB: return SEL_BYTE_HI >> a;
            OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: return a[1] ? SEL_HALF_LO : SEL_HALF_HI;
            OPERATOR_LWL, OPERATOR_SWL:             return SEL_WORD >> a;
            OPERATOR_LWR, OPERATOR_SWR:             return SEL_WORD << inv;
            default:                                return SEL_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [1:0] a,
                                                input logic [31:0] b);
        logic [1:0] inv;
        inv = 2'd3 - a;
        case (op)
            OPERATOR_SB:  return {4{b[7:0]}};
            OPERATOR_SH:  return {2{b[15:0]}};
            OPERATOR_SWL: return b >> {a, 3'b000};
            OPERATOR_SWR: return b << {inv, 3'b000};
            default:      return b;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: extracts/extends the addressed byte or halfword, or
// merges the memory word with operand_b for LWL/LWR (big-endian).
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  operator_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] operand_b_i,
    output logic [31:0] rd_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[31:24];
        case (lane_i)
            2'd0: byte_v = rdata_i[31:24];
            2'd1: byte_v = rdata_i[23:16];
            2'd2: byte_v = rdata_i[15:8];
            2'd3: byte_v = rdata_i[7:0];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = lane_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        rd_data_o = rdata_i;
        case (operator_i)
            OPERATOR_LB:  rd_data_o = {{24{byte_v[7]}}, byte_v};
            OPERATOR_LBU: rd_data_o = {24'h0, byte_v};
            OPERATOR_LH:  rd_data_o = {{16{half_v[15]}}, half_v};
            OPERATOR_LHU: rd_data_o = {16'h0, half_v};
            // LWL fills the register from its top byte down; LWR from its bottom byte up.
            OPERATOR_LWL: begin
                case (lane_i)
                    2'd0: rd_data_o = rdata_i;
                    2'd1: rd_data_o = {rdata_i[23:0], operand_b_i[7:0]};
                    2'd2: rd_data_o = {rdata_i[15:0], operand_b_i[15:0]};
                    default: rd_data_o = {rdata_i[7:0], operand_b_i[23:0]};
                endcase
            end
            OPERATOR_LWR: begin
                case (lane_i)
                    2'd0: rd_data_o = {operand_b_i[31:8], rdata_i[31:24]};
                    2'd1: rd_data_o = {operand_b_i[31:16], rdata_i[31:16]};
                    2'd2: rd_data_o = {operand_b_i[31:24], rdata_i[31:8]};
                    default: rd_data_o = rdata_i;
                endcase
            end
            default: rd_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: registers write-back results and runs req/gnt/rvalid bus
// accesses. Define MEM_ALIGN_EXC_EN to fault misaligned LH/LHU/SH/LW/SW.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_WIDTH    = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  stall_o,
    input  logic [7:0]            operator_i,
    input  logic [15:0]           imm16_i,
    input  logic [31:0]           operand_a_i,
    input  logic [31:0]           operand_b_i,
    input  logic                  rd_we_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [31:0]           rd_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  out_valid_o,
    output logic                  rd_we_o,
    output logic [4:0]            rd_addr_o,
    output logic [31:0]           rd_data_o,
    output logic                  bus_error_o,
    output mem_state_e            state_o
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    mem_state_e             state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]             op_q, op_d;
    logic [1:0]             lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            opb_q, opb_d;
    logic                   wb_we_q, wb_we_d;
    logic [4:0]             wb_addr_q, wb_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   bus_error_q, bus_error_d;
    logic                   rd_we_q, rd_we_d;
    logic [4:0]             rd_addr_q, rd_addr_d;
    logic [31:0]            rd_data_q, rd_data_d;

    logic [31:0] ea;
    logic        misaligned;
    logic        timed_out;
    logic [31:0] load_data;

    assign ea = operand_a_i + {{16{imm16_i[15]}}, imm16_i};

`ifdef MEM_ALIGN_EXC_EN
    assign misaligned = is_misaligned(operator_i, ea[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign timed_out = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_LAST);

    mem_load_align u_load_align (
        .operator_i  (op_q),
        .lane_i      (lane_q),
        .rdata_i     (mem_rdata_i),
        .operand_b_i (opb_q),
        .rd_data_o   (load_data)
    );

    // Handshake: an op is taken in the IDLE cycle where in_valid_i is high; a
    // memory op raises stall_o in that cycle and holds it until the access ends,
    // so the next op must wait. Bus outputs stay stable while mem_req_o is high
    // and mem_gnt_i accepts them in that cycle.
    assign stall_o     = (state_q != STATE_IDLE) ||
                         (in_valid_i && is_mem_op(operator_i) && state_q == STATE_IDLE);
    assign mem_req_o   = (state_q == STATE_REQ);
    assign mem_we_o    = (state_q == STATE_REQ) && is_store(op_q);
    assign mem_addr_o  = addr_q;
    assign mem_sel_o   = sel_q;
    assign mem_wdata_o = wdata_q;
    assign out_valid_o = out_valid_q;
    assign bus_error_o = bus_error_q;
    assign rd_we_o     = rd_we_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        op_d        = op_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        opb_d       = opb_q;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        out_valid_d = 1'b0;
        bus_error_d = 1'b0;
        rd_we_d     = rd_we_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            STATE_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    if (!is_mem_op(operator_i)) begin
                        out_valid_d = 1'b1;
                        rd_we_d     = rd_we_i;
                        rd_addr_d   = rd_addr_i;
                        rd_data_d   = rd_data_i;
                    end else if (misaligned) begin
                        out_valid_d = 1'b1;
                        bus_error_d = 1'b1;
                        rd_we_d     = 1'b0;
                        rd_addr_d   = rd_addr_i;
                        rd_data_d   = '0;
                    end else begin
                        op_d      = operator_i;
                        lane_d    = ea[1:0];
                        addr_d    = {ea[ADDR_WIDTH-1:2], 2'b00};
                        sel_d     = mem_sel(operator_i, ea[1:0]);
                        wdata_d   = store_wdata(operator_i, ea[1:0], operand_b_i);
                        opb_d     = operand_b_i;
                        wb_we_d   = rd_we_i;
                        wb_addr_d = rd_addr_i;
                        state_d   = STATE_REQ;
                    end
                end
            end
            STATE_REQ: begin
                timer_d = timer_q + TIMER_WIDTH'(1);
                if (flush_i) begin
                    // A granted store has no response to drain.
                    state_d = (mem_gnt_i && is_load(op_q)) ? STATE_DRAIN : STATE_IDLE;
                    timer_d = '0;
                end else if (mem_gnt_i) begin
                    if (is_store(op_q)) begin
                        state_d     = STATE_IDLE;
                        out_valid_d = 1'b1;
                        rd_we_d     = 1'b0;
                        rd_addr_d   = wb_addr_q;
                        rd_data_d   = '0;
                    end else begin
                        state_d = STATE_WAIT;
                    end
                end else if (timed_out) begin
                    state_d     = STATE_IDLE;
                    out_valid_d = 1'b1;
                    bus_error_d = 1'b1;
                    rd_we_d     = 1'b0;
                    rd_addr_d   = wb_addr_q;
                    rd_data_d   = '0;
                end
            end
            STATE_WAIT: begin
                timer_d = timer_q + TIMER_WIDTH'(1);
                if (flush_i) begin
                    // A response arriving with the flush is simply dropped.
                    state_d = mem_rvalid_i ? STATE_IDLE : STATE_DRAIN;
                    timer_d = '0;
                end else if (mem_rvalid_i) begin
                    state_d     = STATE_IDLE;
                    out_valid_d = 1'b1;
                    rd_we_d     = wb_we_q;
                    rd_addr_d   = wb_addr_q;
                    rd_data_d   = load_data;
                end else if (timed_out) begin
                    state_d     = STATE_DRAIN;
                    out_valid_d = 1'b1;
                    bus_error_d = 1'b1;
                    rd_we_d     = 1'b0;
                    rd_addr_d   = wb_addr_q;
                    rd_data_d   = '0;
                end
            end
            STATE_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            timer_q     <= '0;
            op_q        <= OPERATOR_NOP;
            lane_q      <= '0;
            addr_q      <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            opb_q       <= '0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            out_valid_q <= 1'b0;
            bus_error_q <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            opb_q       <= opb_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            out_valid_q <= out_valid_d;
            bus_error_q <= bus_error_d;
            rd_we_q     <= rd_we_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, timeout, flush and
// alignment handling against hand-computed write-back and bus values.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clock, reset, flush_i, in_valid_i, stall_o;
    logic [7:0]  operator_i;
    logic [15:0] imm16_i;
    logic [31:0] operand_a_i, operand_b_i, rd_data_i;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_sel_o;
    logic        out_valid_o, rd_we_o, bus_error_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    mem_state_e  state_o;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .TIMER_WIDTH(7)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .stall_o(stall_o), .operator_i(operator_i), .imm16_i(imm16_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .rd_we_i(rd_we_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .rd_we_o(rd_we_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .bus_error_o(bus_error_o),
        .state_o(state_o)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // {bus_error, rd_we, rd_addr, rd_data}
    logic [38:0] exp_q[$];

    int          gnt_lat = 0, rv_lat = 1, rv_cnt = 0, req_wait = 0;
    bit          gnt_en = 1;
    logic [31:0] resp_data = '0;

    int          stall_cnt, req_cnt;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        req_we;

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_wb(input logic err, input logic we, input logic [4:0] a,
                             input logic [31:0] d);
        exp_q.push_back({err, we, a, d});
    endtask

    // memory responder: gnt after gnt_lat waiting cycles, rvalid rv_lat cycles after a load gnt
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clock);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (reset) begin
                rv_cnt = 0; req_wait = 0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = resp_data;
                    end
                end
                if (mem_req_o && gnt_en) begin
                    if (req_wait == gnt_lat) begin
                        mem_gnt_i = 1'b1;
                        req_wait  = 0;
                        if (!mem_we_o) rv_cnt = rv_lat;
                    end else begin
                        req_wait++;
                    end
                end else begin
                    req_wait = 0;
                end
            end
        end
    end

    // scoreboard: every out_valid pulse must match the oldest expected result
    initial begin
        logic [38:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset && out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_bus_error", 64'(bus_error_o), 64'(e[38]));
                    check("wb_rd_we", 64'(rd_we_o), 64'(e[37]));
                    if (e[37]) begin
                        check("wb_rd_addr", 64'(rd_addr_o), 64'(e[36:32]));
                        check("wb_rd_data", 64'(rd_data_o), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    // drive one op for a single cycle, then follow stall_o until it drops
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [15:0] imm,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] rdd);
        int n;
        @(negedge clock);
        operator_i = op; operand_a_i = a; imm16_i = imm; operand_b_i = b;
        rd_we_i = 1'b1; rd_addr_i = rd; rd_data_i = rdd; in_valid_i = 1'b1;
        #1;
        stall_cnt = 0; req_cnt = 0; n = 0;
        while (stall_o && n < 100) begin
            stall_cnt++;
            if (mem_req_o) begin
                if (req_cnt == 0) begin
                    req_addr = mem_addr_o; req_sel = mem_sel_o;
                    req_wdata = mem_wdata_o; req_we = mem_we_o;
                end
                req_cnt++;
            end
            @(negedge clock);
            in_valid_i = 1'b0;
            #1;
            n++;
        end
        check("stall_bound_expired", 64'(n >= 100), 64'd0);
        @(negedge clock);
        in_valid_i = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [15:0] imm, input logic [31:0] b, input logic [31:0] rdata,
                           input int rv, input logic [4:0] rd, input logic [31:0] exp_data,
                           input logic [31:0] exp_addr, input logic [3:0] exp_sel, input int exp_stall);
        gnt_lat = 0; rv_lat = rv; resp_data = rdata;
        expect_wb(1'b0, 1'b1, rd, exp_data);
        run_op(op, a, imm, b, rd, 32'h0);
        check({name, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
        check({name, "_addr"}, 64'(req_addr), 64'(exp_addr));
        check({name, "_sel"}, 64'(req_sel), 64'(exp_sel));
        check({name, "_we"}, 64'(req_we), 64'd0);
    endtask

    task automatic do_store(input string name, input logic [7:0] op, input logic [31:0] a,
                            input logic [15:0] imm, input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                            input logic [31:0] exp_wdata);
        gnt_lat = 0;
        expect_wb(1'b0, 1'b0, rd, 32'h0);
        run_op(op, a, imm, b, rd, 32'h0);
        check({name, "_stall"}, 64'(stall_cnt), 64'd2);
        check({name, "_addr"}, 64'(req_addr), 64'(exp_addr));
        check({name, "_sel"}, 64'(req_sel), 64'(exp_sel));
        check({name, "_wdata"}, 64'(req_wdata), 64'(exp_wdata));
        check({name, "_we"}, 64'(req_we), 64'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; operator_i = OPERATOR_NOP;
        imm16_i = '0; operand_a_i = '0; operand_b_i = '0; rd_we_i = 1'b0;
        rd_addr_i = '0; rd_data_i = '0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_state", 64'(state_o), 64'(STATE_IDLE));
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_mem_req", 64'(mem_req_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_rd_data", 64'(rd_data_o), 64'd0);
        check("reset_bus_error", 64'(bus_error_o), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        expect_wb(1'b0, 1'b1, 5'd3, 32'h1234_5678);
        run_op(OPERATOR_ADDU, 32'h0, 16'h0, 32'h0, 5'd3, 32'h1234_5678);
        check("addu_stall", 64'(stall_cnt), 64'd0);

        do_load("lb", OPERATOR_LB, 32'h1004, 16'hFFFD, 32'h0, 32'h8081_8283, 2, 5'd5,
                32'hFFFF_FF81, 32'h1000, 4'b0100, 4);
        do_store("swr", OPERATOR_SWR, 32'h1000, 16'h0002, 32'h1122_3344, 5'd6,
                 32'h1000, 4'b1110, 32'h2233_4400);
        do_load("lwl", OPERATOR_LWL, 32'h0, 16'h0003, 32'h1122_3344, 32'hAABB_CCDD, 1, 5'd7,
                32'hDD22_3344, 32'h0, 4'b0001, 3);
        do_load("lwr", OPERATOR_LWR, 32'h0, 16'h0001, 32'h1122_3344, 32'hAABB_CCDD, 1, 5'd8,
                32'h1122_AABB, 32'h0, 4'b1100, 3);
        do_load("lhu", OPERATOR_LHU, 32'h2002, 16'h0, 32'h0, 32'h1234_ABCD, 1, 5'd10,
                32'h0000_ABCD, 32'h2000, 4'b0011, 3);
        do_load("lh", OPERATOR_LH, 32'h2000, 16'h0, 32'h0, 32'h8001_5555, 1, 5'd11,
                32'hFFFF_8001, 32'h2000, 4'b1100, 3);
        do_load("lbu", OPERATOR_LBU, 32'h2003, 16'h0, 32'h0, 32'h0000_00F0, 1, 5'd12,
                32'h0000_00F0, 32'h2000, 4'b0001, 3);
        do_store("sb", OPERATOR_SB, 32'h3001, 16'h0, 32'h0000_00A5, 5'd13,
                 32'h3000, 4'b0100, 32'hA5A5_A5A5);
        do_store("swl", OPERATOR_SWL, 32'h3001, 16'h0, 32'h1122_3344, 5'd14,
                 32'h3000, 4'b0111, 32'h0011_2233);
        do_store("sh", OPERATOR_SH, 32'h3002, 16'h0, 32'h0000_BEEF, 5'd15,
                 32'h3000, 4'b0011, 32'hBEEF_BEEF);

        // grant arrives on the third request cycle
        gnt_lat = 2; rv_lat = 1; resp_data = 32'h0102_0304;
        expect_wb(1'b0, 1'b1, 5'd16, 32'h0102_0304);
        run_op(OPERATOR_LW, 32'h40, 16'h0, 32'h0, 5'd16, 32'h0);
        check("lw_slow_stall", 64'(stall_cnt), 64'd5);
        check("lw_slow_req_cycles", 64'(req_cnt), 64'd3);
        gnt_lat = 0;

        // bus never grants: timeout after 4 request cycles
        gnt_en = 1'b0;
        expect_wb(1'b1, 1'b0, 5'd17, 32'h0);
        run_op(OPERATOR_LW, 32'h80, 16'h0, 32'h0, 5'd17, 32'h0);
        check("timeout_stall", 64'(stall_cnt), 64'd5);
        check("timeout_req_cycles", 64'(req_cnt), 64'd4);
        gnt_en = 1'b1;
        expect_wb(1'b0, 1'b1, 5'd18, 32'hCAFE_0001);
        run_op(OPERATOR_ADDU, 32'h0, 16'h0, 32'h0, 5'd18, 32'hCAFE_0001);

        // flush during WAIT, response three cycles later is discarded
        gnt_lat = 0; rv_lat = 4; resp_data = 32'hDEAD_BEEF;
        @(negedge clock);
        operator_i = OPERATOR_LW; operand_a_i = 32'h300; imm16_i = 16'h0;
        rd_addr_i = 5'd19; rd_we_i = 1'b1; in_valid_i = 1'b1;
        @(negedge clock);
        in_valid_i = 1'b0;
        @(negedge clock);
        flush_i = 1'b1;
        #1;
        check("flush_in_wait", 64'(state_o), 64'(STATE_WAIT));
        @(negedge clock);
        flush_i = 1'b0;
        #1;
        check("flush_drain_state", 64'(state_o), 64'(STATE_DRAIN));
        n = 0;
        while (stall_o && n < 50) begin
            n++;
            @(negedge clock);
            #1;
        end
        check("flush_drain_stall", 64'(n), 64'd3);
        expect_wb(1'b0, 1'b1, 5'd20, 32'h0BAD_F00D);
        run_op(OPERATOR_ADDU, 32'h0, 16'h0, 32'h0, 5'd20, 32'h0BAD_F00D);
        check("addu_after_flush_stall", 64'(stall_cnt), 64'd0);

        // misaligned word load
        rv_lat = 1; resp_data = 32'hCAFE_F00D;
`ifdef MEM_ALIGN_EXC_EN
        expect_wb(1'b1, 1'b0, 5'd21, 32'h0);
        run_op(OPERATOR_LW, 32'h2, 16'h0, 32'h0, 5'd21, 32'h0);
        check("lw_misaligned_req_cycles", 64'(req_cnt), 64'd0);
        check("lw_misaligned_stall", 64'(stall_cnt), 64'd1);
`else
        expect_wb(1'b0, 1'b1, 5'd21, 32'hCAFE_F00D);
        run_op(OPERATOR_LW, 32'h2, 16'h0, 32'h0, 5'd21, 32'h0);
        check("lw_misaligned_addr", 64'(req_addr), 64'd0);
        check("lw_misaligned_stall", 64'(stall_cnt), 64'd3);
`endif

        repeat (4) @(negedge clock);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
